// File: rtl/mod_cnt_pkg.sv
// Shared definitions for the modulo-N up/down counter family.
//   DIR_UP / DIR_DN : encodings of the up_dn input.
//   clog2()         : ceiling log2, for deriving WIDTH from MODULUS at
//                     instantiation sites (returns at least 1).
package mod_cnt_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 1;
    while ((64'(1) << width) < 64'(value)) width++;
    return width;
  endfunction

endpackage

// File: rtl/mod_cnt_next.sv
// Combinational next-state logic for mod_n_updown_counter.
// Applies the per-edge priority clr > load > en > hold and detects the
// boundary step that produces the wrap flag.
//   count      : current registered count
//   up_dn      : direction (DIR_UP / DIR_DN)
//   en, clr, load, load_val : control inputs as sampled this cycle
//   wrap       : current sticky flag (only present in saturate mode)
//   next_count : value to register on the next edge
//   next_wrap  : value of the wrap register on the next edge
// Build option: MOD_N_COUNTER_SAT_EN selects saturate mode.
module mod_cnt_next
  import mod_cnt_pkg::*;
#(
  parameter int unsigned MODULUS = 12,
  parameter int unsigned WIDTH   = 4
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up_dn,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`ifdef MOD_N_COUNTER_SAT_EN
  input  logic             wrap,
`endif
  output logic [WIDTH-1:0] next_count,
  output logic             next_wrap
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic at_max;
  logic at_zero;
  logic over;

  assign at_max  = (count == MAX);
  assign at_zero = (count == '0);
  // Only reachable through parameter misuse; forces a legal next value.
  assign over    = (count > MAX);

  always_comb begin
    next_count = count;
    next_wrap  = 1'b0;
    if (clr) begin
      next_count = '0;
    end else if (load) begin
      next_count = (load_val > MAX) ? MAX : load_val;
    end else if (en) begin
`ifdef MOD_N_COUNTER_SAT_EN
      next_wrap = wrap;
      if (up_dn == DIR_UP) begin
        if (at_max || over) begin
          next_count = MAX;
          next_wrap  = wrap | at_max;
        end else begin
          next_count = count + ONE;
        end
      end else begin
        if (at_zero) begin
          next_count = '0;
          next_wrap  = 1'b1;
        end else if (over) begin
          next_count = MAX;
        end else begin
          next_count = count - ONE;
        end
      end
`else
      if (up_dn == DIR_UP) begin
        if (at_max || over) begin
          next_count = '0;
          next_wrap  = at_max;
        end else begin
          next_count = count + ONE;
        end
      end else begin
        if (at_zero) begin
          next_count = MAX;
          next_wrap  = 1'b1;
        end else if (over) begin
          next_count = MAX;
        end else begin
          next_count = count - ONE;
        end
      end
`endif
    end else begin
`ifdef MOD_N_COUNTER_SAT_EN
      next_wrap = wrap;
`endif
    end
  end

endmodule

// File: rtl/mod_n_updown_counter.sv
// Modulo-N binary up/down counter with enable, synchronous clear,
// parallel load (clamped to MODULUS-1), terminal count and wrap flag.
//   clk      : rising-edge clock
//   rst      : asynchronous active-low reset (count=RST_VAL, wrap=0)
//   en       : count enable
//   up_dn    : 1 = up, 0 = down
//   clr      : synchronous clear to 0 (highest priority)
//   load     : synchronous parallel load of load_val
//   load_val : value to load
//   count    : registered count
//   tc       : combinational terminal count, for cascading into en
//   wrap     : registered one-cycle pulse after a wrap step
//              (sticky overflow flag in saturate mode)
// Build option: define MOD_N_COUNTER_SAT_EN for saturate mode.
module mod_n_updown_counter
  import mod_cnt_pkg::*;
#(
  parameter int unsigned MODULUS = 12,
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RST_VAL);

  logic [WIDTH-1:0] next_count;
  logic             next_wrap;

  mod_cnt_next #(
    .MODULUS (MODULUS),
    .WIDTH   (WIDTH)
  ) u_next (
    .count      (count),
    .up_dn      (up_dn),
    .en         (en),
    .clr        (clr),
    .load       (load),
    .load_val   (load_val),
`ifdef MOD_N_COUNTER_SAT_EN
    .wrap       (wrap),
`endif
    .next_count (next_count),
    .next_wrap  (next_wrap)
  );

  // Independent of clr/load so a downstream stage advances on the same
  // edge this stage wraps.
  assign tc = en & ((up_dn == DIR_UP) ? (count == MAX) : (count == '0));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= RST_V;
      wrap  <= 1'b0;
    end else begin
      count <= next_count;
      wrap  <= next_wrap;
    end
  end

endmodule

// File: tb/tb_mod_n_updown_counter.sv
module tb_mod_n_updown_counter;

  localparam int M = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0, up_dn = 1'b1, clr = 1'b0, load = 1'b0;
  logic [3:0] load_val = '0;
  logic [3:0] count;
  logic       tc, wrap;

  logic       c_en = 1'b0, c_clr = 1'b0;
  logic [3:0] c0_count, c1_count;
  logic       c0_tc, c1_tc, c0_wrap, c1_wrap;

  int checks = 0;
  int failures = 0;

  // reference model state
  int m_count = 0;
  bit m_wrap = 1'b0;
  bit exp_tc;
  logic obs_tc;

  always #5 clk = ~clk;

  mod_n_updown_counter #(.MODULUS(12), .WIDTH(4), .RST_VAL(0)) dut (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .count(count), .tc(tc), .wrap(wrap));

  mod_n_updown_counter #(.MODULUS(12), .WIDTH(4), .RST_VAL(0)) c0 (
    .clk(clk), .rst(rst), .en(c_en), .up_dn(1'b1), .clr(c_clr), .load(1'b0),
    .load_val(4'd0), .count(c0_count), .tc(c0_tc), .wrap(c0_wrap));

  mod_n_updown_counter #(.MODULUS(12), .WIDTH(4), .RST_VAL(0)) c1 (
    .clk(clk), .rst(rst), .en(c0_tc), .up_dn(1'b1), .clr(c_clr), .load(1'b0),
    .load_val(4'd0), .count(c1_count), .tc(c1_tc), .wrap(c1_wrap));

  // Arithmetic model of one clock edge.
  function automatic void model_edge(bit e, bit u, bit c, bit l, int lv);
    if (c) begin
      m_count = 0; m_wrap = 1'b0;
    end else if (l) begin
      m_count = (lv >= M) ? M - 1 : lv; m_wrap = 1'b0;
    end else if (e) begin
`ifdef MOD_N_COUNTER_SAT_EN
      if (u) begin
        if (m_count == M - 1) m_wrap = 1'b1; else m_count = m_count + 1;
      end else begin
        if (m_count == 0) m_wrap = 1'b1; else m_count = m_count - 1;
      end
`else
      if (u) begin
        m_wrap = (m_count == M - 1); m_count = (m_count + 1) % M;
      end else begin
        m_wrap = (m_count == 0); m_count = (m_count + M - 1) % M;
      end
`endif
    end else begin
`ifndef MOD_N_COUNTER_SAT_EN
      m_wrap = 1'b0;
`endif
    end
  endfunction

  // Drives one cycle, samples tc mid-cycle, advances the model; no checks.
  task automatic cycle(input bit e, input bit u, input bit c, input bit l, input int lv);
    en = e; up_dn = u; clr = c; load = l; load_val = 4'(lv);
    #2;
    exp_tc = e && (u ? (m_count == M - 1) : (m_count == 0));
    obs_tc = tc;
    @(posedge clk);
    model_edge(e, u, c, l, lv);
    #1;
  endtask

  task automatic test_reset;
    en = 1'b1; up_dn = 1'b1;
    #3;
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (wrap !== 1'b0) begin failures++; $display("FAIL reset_wrap got=%0b exp=0", wrap); end
    #5; // an edge has passed while reset is held
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset_hold got=%0d exp=0", count); end
    en = 1'b0;
    #4 rst = 1'b1;
    @(posedge clk); #1;
    m_count = 0; m_wrap = 1'b0;
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset_release got=%0d exp=0", count); end
  endtask

  task automatic test_count_up;
    for (int i = 0; i < 14; i++) begin
      cycle(1, 1, 0, 0, 0);
      checks++; if (obs_tc !== exp_tc) begin failures++; $display("FAIL up_tc step=%0d got=%0b exp=%0b", i, obs_tc, exp_tc); end
      checks++; if (count !== 4'(m_count)) begin failures++; $display("FAIL up_count step=%0d got=%0d exp=%0d", i, count, m_count); end
      checks++; if (wrap !== m_wrap) begin failures++; $display("FAIL up_wrap step=%0d got=%0b exp=%0b", i, wrap, m_wrap); end
    end
  endtask

  task automatic test_count_down;
    cycle(0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 0, 0, 0);
      checks++; if (obs_tc !== exp_tc) begin failures++; $display("FAIL dn_tc step=%0d got=%0b exp=%0b", i, obs_tc, exp_tc); end
      checks++; if (count !== 4'(m_count)) begin failures++; $display("FAIL dn_count step=%0d got=%0d exp=%0d", i, count, m_count); end
      checks++; if (wrap !== m_wrap) begin failures++; $display("FAIL dn_wrap step=%0d got=%0b exp=%0b", i, wrap, m_wrap); end
    end
  endtask

  task automatic test_load_clr;
    cycle(0, 1, 0, 1, 5);
    checks++; if (count !== 4'd5) begin failures++; $display("FAIL load5 got=%0d exp=5", count); end
    cycle(0, 1, 0, 1, 14);
    checks++; if (count !== 4'd11) begin failures++; $display("FAIL load_clamp got=%0d exp=11", count); end
    cycle(0, 1, 1, 1, 14);
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL clr_over_load got=%0d exp=0", count); end
    cycle(0, 1, 0, 1, 11);
    cycle(1, 1, 0, 1, 11);
    checks++; if (obs_tc !== 1'b1) begin failures++; $display("FAIL load_en_tc got=%0b exp=1", obs_tc); end
    checks++; if (count !== 4'd11) begin failures++; $display("FAIL load_en_count got=%0d exp=11", count); end
    checks++; if (wrap !== 1'b0) begin failures++; $display("FAIL load_en_wrap got=%0b exp=0", wrap); end
  endtask

  task automatic test_async_reset;
    cycle(0, 1, 0, 1, 6);
    cycle(1, 1, 0, 0, 0); // count now 7, en still high
    #3 rst = 1'b0;
    #1;
    m_count = 0; m_wrap = 1'b0;
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL async_count got=%0d exp=0", count); end
    checks++; if (wrap !== 1'b0) begin failures++; $display("FAIL async_wrap got=%0b exp=0", wrap); end
    @(posedge clk); #1;
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL async_held got=%0d exp=0", count); end
    #2 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(1, 1, 0, 0, 0);
      checks++; if (count !== 4'(m_count)) begin failures++; $display("FAIL async_resume step=%0d got=%0d exp=%0d", i, count, m_count); end
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 300; i++) begin
      int r;
      r = int'($urandom_range(0, 15));
      cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), r == 0, r == 1,
            int'($urandom_range(0, 15)));
      checks++; if (obs_tc !== exp_tc) begin failures++; $display("FAIL rnd_tc step=%0d got=%0b exp=%0b", i, obs_tc, exp_tc); end
      checks++; if (count !== 4'(m_count)) begin failures++; $display("FAIL rnd_count step=%0d got=%0d exp=%0d", i, count, m_count); end
      checks++; if (wrap !== m_wrap) begin failures++; $display("FAIL rnd_wrap step=%0d got=%0b exp=%0b", i, wrap, m_wrap); end
    end
  endtask

  task automatic test_cascade;
    int pulses;
    int n0, n1;
    pulses = 0;
    c_en = 1'b0; c_clr = 1'b1;
    @(posedge clk); #1;
    c_clr = 1'b0; c_en = 1'b1;
    for (int n = 1; n <= 144; n++) begin
      @(posedge clk); #1;
      n0 = n % M;
      n1 = (n / M) % M;
      if (c1_wrap === 1'b1) pulses++;
      checks++; if (c0_count !== 4'(n0) || c1_count !== 4'(n1)) begin
        failures++; $display("FAIL cascade n=%0d got=%0d,%0d exp=%0d,%0d", n, c1_count, c0_count, n1, n0);
      end
    end
    c_en = 1'b0;
    checks++; if (pulses != 1) begin failures++; $display("FAIL cascade_wrap_pulses got=%0d exp=1", pulses); end
  endtask

`ifdef MOD_N_COUNTER_SAT_EN
  task automatic test_saturate;
    cycle(0, 1, 1, 0, 0);
    for (int i = 1; i <= 15; i++) begin
      cycle(1, 1, 0, 0, 0);
      checks++; if (count !== 4'(m_count) || wrap !== m_wrap) begin
        failures++; $display("FAIL sat_up clk=%0d got=%0d/%0b exp=%0d/%0b", i, count, wrap, m_count, m_wrap);
      end
    end
    checks++; if (count !== 4'd11) begin failures++; $display("FAIL sat_final got=%0d exp=11", count); end
    cycle(0, 0, 0, 0, 0);
    checks++; if (wrap !== 1'b1) begin failures++; $display("FAIL sat_sticky got=%0b exp=1", wrap); end
    cycle(0, 1, 1, 0, 0);
    checks++; if (wrap !== 1'b0) begin failures++; $display("FAIL sat_clr got=%0b exp=0", wrap); end
  endtask
`endif

  initial begin
    test_reset;
    test_count_up;
    test_count_down;
    test_load_clr;
    test_async_reset;
`ifdef MOD_N_COUNTER_SAT_EN
    test_saturate;
`endif
    test_random;
    test_cascade;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mod_n_updown_counter.md
Name: mod_n_updown_counter

Overview:
- Parametrised successor to the fixed mod-12 counter.
- Modulo-N binary counter with:
  - runtime up/down direction
  - count enable
  - synchronous clear
  - parallel load
  - terminal-count output for cascading
  - registered wrap pulse
- Used standalone as a divider/sequencer, or chained (tc of stage k drives en of stage k+1) to build multi-digit counters such as BCD or clock/timer digits.

Parameters:
- MODULUS, 12, number of states; count sequence is 0..MODULUS-1; legal range 2..2^WIDTH.
- WIDTH, 4, count width in bits; must satisfy 2^WIDTH >= MODULUS.
- RST_VAL, 0, value loaded on reset; must be < MODULUS.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; asynchronous assert, active-low (0 = reset).
- en  input  1  count enable; counts one step per clk when high.
- up_dn  input  1  1 = count up, 0 = count down.
- clr  input  1  synchronous clear to 0.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  value to load.
- count  output  WIDTH  current count, registered.
- tc  output  1  terminal count, combinational: en & (up_dn ? count==MODULUS-1 : count==0).
- wrap  output  1  registered one-cycle pulse, high in the cycle after a wrap step occurred.

Behaviour:
- Reset:
  - rst=0 asynchronously forces count=RST_VAL and wrap=0, regardless of clk.
  - Release is sampled at the next rising edge.
  - Reset asserted mid-sequence aborts immediately; no wrap pulse is produced.
- Per-edge priority (highest first): clr > load > en > hold.
  - clr=1: count<=0, wrap<=0.
  - load=1: count<=load_val if load_val<MODULUS, else MODULUS-1 (clamp); wrap<=0.
  - en=1, up_dn=1: count<=(count==MODULUS-1) ? 0 : count+1.
  - en=1, up_dn=0: count<=(count==0) ? MODULUS-1 : count-1.
  - en=0: count holds, wrap<=0.
- wrap:
  - Set to 1 on the edge where a counting step crosses the boundary (MODULUS-1->0 up, 0->MODULUS-1 down).
  - Cleared on every other edge.
  - Equals tc registered, except when clr or load wins priority.
- tc:
  - Purely combinational; must not depend on clr/load.
  - Lets the downstream stage advance in the same edge as the wrap.
- Direction change: takes effect on the same edge it is sampled; no extra latency.
- Out-of-range count, reachable only through a parameter misuse: the next enabled step goes to 0 (up) or MODULUS-1 (down); never stalls.
- Arithmetic: WIDTH bits, no truncation warnings; compare against MODULUS-1 cast to WIDTH.
- Latency: count updates one clk after the inputs are sampled.

Optional Feature:
- Macro: MOD_N_COUNTER_SAT_EN.
- Defined (saturate mode): an enabled step at the boundary holds count at MODULUS-1 (up) or 0 (down) instead of wrapping.
  - wrap becomes a sticky overflow flag, set on the first saturating step.
  - The flag is cleared by clr, load or reset.
  - tc is unchanged.
- Undefined: wrap-around behaviour as above; wrap is a one-cycle pulse.

Decomposition:
- Shared package mod_cnt_pkg holds:
  - direction constants DIR_UP=1'b1, DIR_DN=1'b0
  - a function clog2 for deriving WIDTH at instantiation sites.
- One natural sub-module: mod_cnt_next.
  - Combinational next-state and boundary detect.
  - Inputs: count, up_dn, en, clr, load, load_val.
  - Outputs: next_count, next_wrap.
  - Lets the top hold only the two registers and tc.

Test Plan (MODULUS=12, WIDTH=4, RST_VAL=0):
1. rst=0 for 10 ns, then en=1, up_dn=1 for 14 clks -> count 0,1..11,0,1; tc high only while count=11; wrap high exactly one cycle after the 11->0 edge.
2. From count=0, up_dn=0, en=1 -> count 11,10,9; tc high at count=0; wrap pulses after the 0->11 edge.
3. At count=5, load=1, load_val=14 -> count=11 (clamped); same cycle with clr=1 -> count=0 (clr wins); load with en=1 at count=11 -> no wrap pulse.
4. At count=7 mid-count, drive rst low between clock edges -> count=0 immediately (asynchronous), wrap=0; counting resumes from 0 after release.
5. Two instances cascaded (tc0 drives en1), 144 clks up -> stage1 counts 0..11 once, both stages read 0 at the end, stage1 wrap pulses once.
6. With MOD_N_COUNTER_SAT_EN defined, count up 15 clks -> count stays 11 from clk 11 on; wrap set at the first saturating step and held until clr=1.
